top_hls_deadlock_report_unit: RTL and testbench

- Downstream consumer of the per-instance deadlock monitor's registered `block` output.
- Qualifies `block`: it must stay high for THRESH consecutive cycles before being declared a deadlock.
- On qualification, captures a timestamped snapshot of the AXIS block flags and instance idle flags.
- Presents the snapshot once on a valid/ready report channel and keeps a sticky `deadlock` flag until cleared.

---
 rtl/top_hls_deadlock_report_unit.sv | 131 +++++++++++++
 tb/tb_top_hls_deadlock_report_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/top_hls_deadlock_report_unit.sv
// top_hls_deadlock_report_unit
// Qualifies the monitor's registered `block` over THRESH consecutive cycles.
// On the qualifying sample it captures {ts, axis_block_sigs, inst_idle_sigs}.
// The snapshot is offered once on a valid/ready channel, and a sticky
// `deadlock` flag stays set until `clear`.
// Optional build macro DEADLOCK_REPORT_REARM_EN: in HOLD, a block=0 sample
// re-arms detection without a software clear.
module top_hls_deadlock_report_unit #(
  parameter int AXIS_W = 3,
  parameter int IDLE_W = 2,
  parameter int THRESH = 1000,
  parameter int CNT_W  = 16,
  parameter int TS_W   = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            block,
  input  logic [AXIS_W-1:0]               axis_block_sigs,
  input  logic [IDLE_W-1:0]               inst_idle_sigs,
  input  logic                            clear,
  output logic                            report_valid,
  input  logic                            report_ready,
  output logic [TS_W+AXIS_W+IDLE_W-1:0]   report_data,
  output logic                            deadlock,
  output logic [CNT_W-1:0]                block_cnt
);

  localparam int DW = TS_W + AXIS_W + IDLE_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Count value seen on the sample just before the THRESH-th high sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    REPORT,
    HOLD
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              dl, dl_n;
  logic [DW-1:0]     data, data_n;
  logic [TS_W-1:0]   ts;
  logic [DW-1:0]     snapshot;

  assign snapshot = {ts, axis_block_sigs, inst_idle_sigs};

  // Free-running cycle timestamp; wraps naturally at 2^TS_W.
  always_ff @(posedge clock) begin
    if (reset) ts <= '0;
    else       ts <= ts + 1'b1;
  end

  // State, run-length counter, sticky flag and snapshot registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      dl    <= 1'b0;
      data  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dl    <= dl_n;
      data  <= data_n;
    end
  end

  // Next-state logic; clear overrides every state transition and capture.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dl_n    = dl;
    data_n  = data;
    if (clear) begin
      state_n = IDLE;
      cnt_n   = '0;
      dl_n    = 1'b0;
      data_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (block) begin
            cnt_n = CNT_W'(1);
            // With THRESH=1 the first high sample already qualifies.
            if (THRESH == 1) begin
              data_n  = snapshot;
              dl_n    = 1'b1;
              state_n = REPORT;
            end else begin
              state_n = COUNT;
            end
          end
        end
        COUNT: begin
          if (!block) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              data_n  = snapshot;
              dl_n    = 1'b1;
              state_n = REPORT;
            end
          end
        end
        REPORT: begin
          if (report_ready) state_n = HOLD;
        end
        HOLD: begin
`ifdef DEADLOCK_REPORT_REARM_EN
          if (!block) begin
            cnt_n   = '0;
            dl_n    = 1'b0;
            state_n = IDLE;
          end
`endif
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign report_valid = (state == REPORT);
  assign report_data  = data;
  assign deadlock     = dl;
  assign block_cnt    = cnt;

endmodule

// File: tb/tb_top_hls_deadlock_report_unit.sv
// Bench for top_hls_deadlock_report_unit (THRESH=4, TS_W=4).
// Expected snapshots are pushed when the qualifying sample is driven and
// popped when the report handshake happens.
module tb_top_hls_deadlock_report_unit;

  localparam int AXIS_W = 3;
  localparam int IDLE_W = 2;
  localparam int THRESH = 4;
  localparam int CNT_W  = 16;
  localparam int TS_W   = 4;
  localparam int DW     = TS_W + AXIS_W + IDLE_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              block = 1'b0;
  logic [AXIS_W-1:0] axis_block_sigs = '0;
  logic [IDLE_W-1:0] inst_idle_sigs = '0;
  logic              clear = 1'b0;
  logic              report_ready = 1'b0;
  logic              report_valid;
  logic [DW-1:0]     report_data;
  logic              deadlock;
  logic [CNT_W-1:0]  block_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] e;
  logic [TS_W-1:0] mts;

  top_hls_deadlock_report_unit #(
    .AXIS_W(AXIS_W), .IDLE_W(IDLE_W), .THRESH(THRESH), .CNT_W(CNT_W), .TS_W(TS_W)
  ) dut (
    .clock(clock), .reset(reset), .block(block),
    .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .clear(clear), .report_valid(report_valid), .report_ready(report_ready),
    .report_data(report_data), .deadlock(deadlock), .block_cnt(block_cnt)
  );

  always #5 clock = ~clock;

  // Reference timestamp: counts cycles since reset.
  always @(posedge clock) begin
    if (reset) mts <= '0;
    else       mts <= mts + 1'b1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ts(input logic [TS_W-1:0] t);
    for (int k = 0; k < 40 && mts != t; k++) tick();
    if (mts != t) begin
      total_cnt++;
      $display("FAIL wait_ts got %0d exp %0d", mts, t);
    end
  endtask

  // Drive THRESH high samples; the last one qualifies and is queued.
  task automatic qualify(input logic [AXIS_W-1:0] ax, input logic [IDLE_W-1:0] id);
    block = 1'b1;
    axis_block_sigs = ax;
    inst_idle_sigs = id;
    for (int i = 0; i < THRESH; i++) begin
      if (i == THRESH - 1) exp_q.push_back({mts, ax, id});
      tick();
    end
    block = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    total_cnt++; if (report_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", report_valid); else pass_cnt++;
    total_cnt++; if (report_data !== '0) $display("FAIL reset_data got %h exp 0", report_data); else pass_cnt++;
    total_cnt++; if (deadlock !== 1'b0) $display("FAIL reset_deadlock got %b exp 0", deadlock); else pass_cnt++;
    total_cnt++; if (block_cnt !== '0) $display("FAIL reset_cnt got %0d exp 0", block_cnt); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_detect();
    wait_ts(4'd10);
    block = 1'b1; axis_block_sigs = 3'b101; inst_idle_sigs = 2'b10;
    for (int i = 0; i < THRESH; i++) begin
      if (i == THRESH - 1) exp_q.push_back({mts, 3'b101, 2'b10});
      tick();
      total_cnt++; if (block_cnt !== CNT_W'(i + 1)) $display("FAIL detect_cnt got %0d exp %0d", block_cnt, i + 1); else pass_cnt++;
      if (i < THRESH - 1) begin
        total_cnt++; if (report_valid !== 1'b0) $display("FAIL detect_early_valid got %b exp 0", report_valid); else pass_cnt++;
      end
    end
    block = 1'b0;
    total_cnt++; if (report_valid !== 1'b1) $display("FAIL detect_valid got %b exp 1", report_valid); else pass_cnt++;
    total_cnt++; if (deadlock !== 1'b1) $display("FAIL detect_deadlock got %b exp 1", deadlock); else pass_cnt++;
    total_cnt++; if (report_data[DW-1 -: TS_W] !== 4'd13) $display("FAIL detect_ts got %0d exp 13", report_data[DW-1 -: TS_W]); else pass_cnt++;
    report_ready = 1'b1;
    e = exp_q.pop_front();
    total_cnt++; if (report_data !== e) $display("FAIL detect_data got %h exp %h", report_data, e); else pass_cnt++;
    tick();
    report_ready = 1'b0;
    total_cnt++; if (report_valid !== 1'b0) $display("FAIL detect_post_valid got %b exp 0", report_valid); else pass_cnt++;
    total_cnt++; if (deadlock !== 1'b1) $display("FAIL detect_sticky got %b exp 1", deadlock); else pass_cnt++;
    clear = 1'b1; tick(); clear = 1'b0;
    total_cnt++; if (deadlock !== 1'b0) $display("FAIL clear_deadlock got %b exp 0", deadlock); else pass_cnt++;
    total_cnt++; if (report_data !== '0) $display("FAIL clear_data got %h exp 0", report_data); else pass_cnt++;
  endtask

  task automatic test_interrupted_run();
    logic pat [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int   expc [7] = '{1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 7; i++) begin
      block = pat[i];
      tick();
      total_cnt++; if (block_cnt !== CNT_W'(expc[i])) $display("FAIL run_cnt[%0d] got %0d exp %0d", i, block_cnt, expc[i]); else pass_cnt++;
      total_cnt++; if (deadlock !== 1'b0) $display("FAIL run_deadlock[%0d] got %b exp 0", i, deadlock); else pass_cnt++;
    end
    total_cnt++; if (report_valid !== 1'b0) $display("FAIL run_valid got %b exp 0", report_valid); else pass_cnt++;
    block = 1'b0; tick();
    total_cnt++; if (block_cnt !== '0) $display("FAIL run_drop_cnt got %0d exp 0", block_cnt); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    qualify(3'b011, 2'b01);
    for (int i = 0; i < 5; i++) begin
      axis_block_sigs = 3'($urandom);
      inst_idle_sigs = 2'($urandom);
      tick();
      total_cnt++; if (report_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b exp 1", i, report_valid); else pass_cnt++;
      total_cnt++; if (report_data !== exp_q[0]) $display("FAIL bp_data[%0d] got %h exp %h", i, report_data, exp_q[0]); else pass_cnt++;
    end
    report_ready = 1'b1;
    e = exp_q.pop_front();
    total_cnt++; if (report_data !== e) $display("FAIL bp_hs_data got %h exp %h", report_data, e); else pass_cnt++;
    tick();
    report_ready = 1'b0;
    total_cnt++; if (report_valid !== 1'b0) $display("FAIL bp_post_valid got %b exp 0", report_valid); else pass_cnt++;
    total_cnt++; if (deadlock !== 1'b1) $display("FAIL bp_deadlock got %b exp 1", deadlock); else pass_cnt++;
    block = 1'b1; tick(); tick();
    total_cnt++; if (block_cnt !== CNT_W'(THRESH)) $display("FAIL hold_cnt got %0d exp %0d", block_cnt, THRESH); else pass_cnt++;
    total_cnt++; if (report_valid !== 1'b0) $display("FAIL hold_valid got %b exp 0", report_valid); else pass_cnt++;
    block = 1'b0; tick();
`ifdef DEADLOCK_REPORT_REARM_EN
    total_cnt++; if (deadlock !== 1'b0) $display("FAIL rearm_deadlock got %b exp 0", deadlock); else pass_cnt++;
    total_cnt++; if (block_cnt !== '0) $display("FAIL rearm_cnt got %0d exp 0", block_cnt); else pass_cnt++;
`else
    total_cnt++; if (deadlock !== 1'b1) $display("FAIL hold_low_deadlock got %b exp 1", deadlock); else pass_cnt++;
    total_cnt++; if (block_cnt !== CNT_W'(THRESH)) $display("FAIL hold_low_cnt got %0d exp %0d", block_cnt, THRESH); else pass_cnt++;
`endif
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_clear_vs_ready();
    qualify(3'b110, 2'b11);
    total_cnt++; if (report_valid !== 1'b1) $display("FAIL cvr_valid got %b exp 1", report_valid); else pass_cnt++;
    clear = 1'b1; report_ready = 1'b1;
    tick();
    clear = 1'b0; report_ready = 1'b0;
    exp_q.delete();
    total_cnt++; if (report_valid !== 1'b0) $display("FAIL cvr_post_valid got %b exp 0", report_valid); else pass_cnt++;
    total_cnt++; if (deadlock !== 1'b0) $display("FAIL cvr_deadlock got %b exp 0", deadlock); else pass_cnt++;
    total_cnt++; if (block_cnt !== '0) $display("FAIL cvr_cnt got %0d exp 0", block_cnt); else pass_cnt++;
    total_cnt++; if (report_data !== '0) $display("FAIL cvr_data got %h exp 0", report_data); else pass_cnt++;
    tick();
    total_cnt++; if (report_valid !== 1'b0) $display("FAIL cvr_late_valid got %b exp 0", report_valid); else pass_cnt++;
  endtask

  task automatic test_reset_in_count();
    block = 1'b1; axis_block_sigs = 3'b001; inst_idle_sigs = 2'b01;
    tick(); tick();
    total_cnt++; if (block_cnt !== CNT_W'(2)) $display("FAIL rc_pre_cnt got %0d exp 2", block_cnt); else pass_cnt++;
    reset = 1'b1; tick(); reset = 1'b0;
    total_cnt++; if (block_cnt !== '0) $display("FAIL rc_cnt got %0d exp 0", block_cnt); else pass_cnt++;
    total_cnt++; if (deadlock !== 1'b0) $display("FAIL rc_deadlock got %b exp 0", deadlock); else pass_cnt++;
    total_cnt++; if (report_valid !== 1'b0) $display("FAIL rc_valid got %b exp 0", report_valid); else pass_cnt++;
    for (int i = 0; i < THRESH; i++) begin
      if (i == THRESH - 1) exp_q.push_back({mts, 3'b001, 2'b01});
      tick();
      total_cnt++; if (report_valid !== (i == THRESH - 1)) $display("FAIL rc_valid[%0d] got %b exp %b", i, report_valid, (i == THRESH - 1)); else pass_cnt++;
    end
    block = 1'b0;
    report_ready = 1'b1;
    e = exp_q.pop_front();
    total_cnt++; if (report_data !== e) $display("FAIL rc_data got %h exp %h", report_data, e); else pass_cnt++;
    tick();
    report_ready = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_ts_wrap();
    wait_ts(4'd12);
    qualify(3'b111, 2'b01);
    total_cnt++; if (report_data[DW-1 -: TS_W] !== 4'd15) $display("FAIL wrap_ts1 got %0d exp 15", report_data[DW-1 -: TS_W]); else pass_cnt++;
    report_ready = 1'b1;
    e = exp_q.pop_front();
    total_cnt++; if (report_data !== e) $display("FAIL wrap_data1 got %h exp %h", report_data, e); else pass_cnt++;
    tick();
    report_ready = 1'b0;
`ifdef DEADLOCK_REPORT_REARM_EN
    tick();
    total_cnt++; if (deadlock !== 1'b0) $display("FAIL wrap_rearm got %b exp 0", deadlock); else pass_cnt++;
`else
    clear = 1'b1; tick(); clear = 1'b0;
`endif
    qualify(3'b010, 2'b10);
    total_cnt++; if (report_valid !== 1'b1) $display("FAIL wrap_valid2 got %b exp 1", report_valid); else pass_cnt++;
    total_cnt++; if (report_data[DW-1 -: TS_W] !== 4'd5) $display("FAIL wrap_ts2 got %0d exp 5", report_data[DW-1 -: TS_W]); else pass_cnt++;
    report_ready = 1'b1;
    e = exp_q.pop_front();
    total_cnt++; if (report_data !== e) $display("FAIL wrap_data2 got %h exp %h", report_data, e); else pass_cnt++;
    tick();
    report_ready = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_detect();
    test_interrupted_run();
    test_backpressure();
    test_clear_vs_ready();
    test_reset_in_count();
    test_ts_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
